// File: rtl/i2c_codec_target.sv
// i2c_codec_target: write-only I2C target modelling the WM8731 control port.
// Oversamples SCL/SDA on clk, decodes START/STOP, the address byte and 16-bit
// register words {reg_addr[6:0], data[8:0]}, drives ACK, and holds the ten
// 9-bit codec registers for combinational readback.
// Build option: define I2C_GLITCH_FILTER_EN to add a FILTER_LEN-sample
// agreement filter on both lines after the synchronizers.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus free or after reset; waiting for START
// ADDR     | shifting in the address byte
// ADDR_ACK | own write address matched; driving ACK
// BYTE1    | shifting in {reg_addr, data[8]}
// ACK1     | driving ACK for byte 1
// BYTE2    | shifting in data[7:0]
// ACK2     | driving ACK for byte 2; word commits on release
// IGNORE   | not addressed (or read request); waiting for START/STOP
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
`ifdef I2C_GLITCH_FILTER_EN
    ,
    parameter int FILTER_LEN = 3
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    input  logic [3:0] reg_rd_addr,
    output logic [8:0] reg_rd_data,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE
    } state_t;

    localparam logic [8:0] REG_DEFAULT [10] = '{
        9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
        9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
    };

    // Edges are ignored until the conditioning pipeline holds real bus values,
    // so a reset released mid-transfer cannot fabricate a START or STOP.
`ifdef I2C_GLITCH_FILTER_EN
    localparam int SETTLE = 3 + FILTER_LEN;
`else
    localparam int SETTLE = 3;
`endif

    state_t     state_q, state_d;
    logic [8:0] regs_q [10];
    logic       scl_s1, scl_s2, sda_s1, sda_s2;
    logic       scl_f, sda_f, scl_prev, sda_prev;
    logic [4:0] settle_q;
    logic [7:0] shift_q, byte1_q, byte2_q;
    logic [3:0] bit_cnt_q;
    logic       bit_seen_q;
    logic       scl_rise, scl_fall, start_det, stop_det, bit_done, byte_done;
    logic       abort_word, addr_ok, rd_err, cap_b1, cap_b2, commit, sda_drive;

    // Two-flop synchronizers, idle-high like the bus
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= I2C_SCLK;
            scl_s2 <= scl_s1;
            sda_s1 <= I2C_SDAT;
            sda_s2 <= sda_s1;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [FILTER_LEN-2:0] scl_hist_q, sda_hist_q;
    logic [FILTER_LEN-1:0] scl_win, sda_win;
    logic                  scl_filt_q, sda_filt_q;

    assign scl_win = {scl_hist_q, scl_s2};
    assign sda_win = {sda_hist_q, sda_s2};
    assign scl_f   = (scl_win == '1) ? 1'b1 : (scl_win == '0) ? 1'b0 : scl_filt_q;
    assign sda_f   = (sda_win == '1) ? 1'b1 : (sda_win == '0) ? 1'b0 : sda_filt_q;

    // Sample history; a line only moves once the whole window agrees
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= scl_win[FILTER_LEN-2:0];
            sda_hist_q <= sda_win[FILTER_LEN-2:0];
            scl_filt_q <= scl_f;
            sda_filt_q <= sda_f;
        end
    end
`else
    assign scl_f = scl_s2;
    assign sda_f = sda_s2;
`endif

    assign scl_rise  = scl_f & ~scl_prev & (settle_q == '0);
    assign scl_fall  = ~scl_f & scl_prev & (settle_q == '0);
    assign start_det = scl_f & scl_prev & sda_prev & ~sda_f & (settle_q == '0);
    assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f & (settle_q == '0);
    // A bit counts only once a rising edge has been seen before its falling edge
    assign bit_done  = scl_fall & bit_seen_q;
    assign byte_done = bit_done & (bit_cnt_q == 4'd1);

    // Previous filtered values, settle timer, bit shifter and bit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_prev   <= 1'b1;
            sda_prev   <= 1'b1;
            settle_q   <= 5'(SETTLE);
            shift_q    <= '0;
            bit_cnt_q  <= 4'd8;
            bit_seen_q <= 1'b0;
        end else begin
            scl_prev <= scl_f;
            sda_prev <= sda_f;
            if (settle_q != '0)
                settle_q <= settle_q - 5'd1;
            if (scl_rise)
                shift_q <= {shift_q[6:0], sda_f};
            if (start_det)
                bit_seen_q <= 1'b0;
            else if (scl_rise)
                bit_seen_q <= 1'b1;
            else if (scl_fall)
                bit_seen_q <= 1'b0;
            if (start_det)
                bit_cnt_q <= 4'd8;
            else if (state_q inside {ADDR, BYTE1, BYTE2}) begin
                if (bit_done)
                    bit_cnt_q <= (bit_cnt_q == 4'd1) ? 4'd8 : bit_cnt_q - 4'd1;
            end else
                bit_cnt_q <= 4'd8;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        state_d    = state_q;
        abort_word = 1'b0;
        addr_ok    = 1'b0;
        rd_err     = 1'b0;
        cap_b1     = 1'b0;
        cap_b2     = 1'b0;
        commit     = 1'b0;
        if (start_det || stop_det) begin
            state_d    = start_det ? ADDR : IDLE;
            abort_word = ((state_q == BYTE1) && (bit_cnt_q != 4'd8)) ||
                         (state_q inside {ACK1, BYTE2, ACK2});
        end else begin
            unique case (state_q)
                ADDR: if (byte_done) begin
                    if (shift_q == {DEV_ADDR, 1'b0}) begin
                        state_d = ADDR_ACK;
                        addr_ok = 1'b1;
                    end else begin
                        state_d = IGNORE;
                        rd_err  = shift_q[0];
                    end
                end
                ADDR_ACK: if (bit_done) state_d = BYTE1;
                BYTE1: if (byte_done) begin
                    state_d = ACK1;
                    cap_b1  = 1'b1;
                end
                ACK1: if (bit_done) state_d = BYTE2;
                BYTE2: if (byte_done) begin
                    state_d = ACK2;
                    cap_b2  = 1'b1;
                end
                ACK2: if (bit_done) begin
                    state_d = BYTE1;
                    commit  = 1'b1;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State register, status pulses, word capture and register-file commit
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            busy      <= 1'b0;
            err       <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            byte1_q   <= '0;
            byte2_q   <= '0;
            regs_q    <= REG_DEFAULT;
        end else begin
            state_q   <= state_d;
            err       <= rd_err | abort_word;
            wr_strobe <= commit;
            if (start_det || stop_det)
                busy <= 1'b0;
            else if (addr_ok)
                busy <= 1'b1;
            if (cap_b1)
                byte1_q <= shift_q;
            if (cap_b2)
                byte2_q <= shift_q;
            if (commit) begin
                wr_addr <= byte1_q[7:1];
                wr_data <= {byte1_q[0], byte2_q};
                if (byte1_q[7:1] < 7'd10)
                    regs_q[byte1_q[4:1]] <= {byte1_q[0], byte2_q};
                else if (byte1_q[7:1] == 7'h0F)
                    regs_q <= REG_DEFAULT;
            end
        end
    end

    // ACK drive; a START/STOP seen during ACK releases the line immediately
    assign sda_drive = (state_q inside {ADDR_ACK, ACK1, ACK2}) && !start_det && !stop_det;
    assign I2C_SDAT  = sda_drive ? 1'b0 : 1'bz;

    // Combinational readback, zero beyond the last register
    always_comb begin
        reg_rd_data = 9'h000;
        if (reg_rd_addr < 4'd10)
            reg_rd_data = regs_q[reg_rd_addr];
    end

endmodule

// File: tb/tb_i2c_codec_target.sv
// Bench for i2c_codec_target: a bit-banged I2C master drives directed and
// random write transactions; a transaction-level model predicts ACKs,
// committed words, error pulses and register contents.
module tb_i2c_codec_target;

    localparam int H = 8;   // SCL phase length in clk

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_low;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       wr_strobe, busy, err;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    wire        sda_bus;

    pullup (sda_bus);
    assign sda_bus = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_codec_target dut (
        .clk        (clk),
        .reset      (reset),
        .I2C_SCLK   (scl),
        .I2C_SDAT   (sda_bus),
        .reg_rd_addr(rd_addr),
        .reg_rd_data(rd_data),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .err        (err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_err_seen = 0;
    logic [15:0] strobe_q [$];
    logic [15:0] exp_q [$];
    logic [7:0]  tx_q [$];
    logic [8:0]  m_regs [10];
    logic [8:0]  def_regs [10];
    logic [15:0] last_word;
    int          exp_err;

    // Record observed pulses away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            if (err) n_err_seen++;
            if (wr_strobe) strobe_q.push_back({wr_addr, wr_data});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void model_defaults();
        for (int i = 0; i < 10; i++) m_regs[i] = def_regs[i];
    endfunction

    function automatic void model_commit(input logic [7:0] b1, input logic [7:0] b2);
        logic [6:0] a;
        logic [8:0] d;
        a = b1[7:1];
        d = {b1[0], b2};
        exp_q.push_back({a, d});
        last_word = {a, d};
        if (a < 7'd10) m_regs[a[3:0]] = d;
        else if (a == 7'h0F) model_defaults();
    endfunction

    task automatic check_regs(input string tag);
        for (int r = 0; r < 10; r++) begin
            rd_addr = 4'(r);
            #1;
            check($sformatf("%s_R%0d", tag, r), 32'(rd_data), 32'(m_regs[r]));
        end
    endtask

    task automatic i2c_start();
        if (scl == 1'b0) begin
            wait_clk(2); m_low = 1'b0; wait_clk(H);
            scl = 1'b1; wait_clk(H);
        end else begin
            m_low = 1'b0; wait_clk(H);
        end
        m_low = 1'b1; wait_clk(H);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(2); m_low = 1'b1; wait_clk(H);
        scl = 1'b1; wait_clk(H);
        m_low = 1'b0; wait_clk(H);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            wait_clk(2); m_low = !b[i]; wait_clk(H);
            scl = 1'b1; wait_clk(H);
            scl = 1'b0;
        end
    endtask

    task automatic ack_bit(output logic acked);
        wait_clk(2); m_low = 1'b0; wait_clk(H);
        scl = 1'b1; wait_clk(H / 2);
        acked = (sda_bus === 1'b0);
        wait_clk(H / 2);
        scl = 1'b0;
    endtask

    // One transaction: START, tx_q bytes, optional partial byte, STOP
    task automatic run_xfer(input int partial, input logic [7:0] pbyte);
        logic acked, addressed;
        int   err0, nd, nmin;
        err0 = n_err_seen;
        strobe_q.delete();
        exp_q.delete();
        addressed = (tx_q[0] == 8'h34);
        exp_err = (!addressed && tx_q[0][0]) ? 1 : 0;
        nd = tx_q.size() - 1;
        i2c_start();
        for (int i = 0; i < tx_q.size(); i++) begin
            send_bits(tx_q[i], 8);
            ack_bit(acked);
            check($sformatf("ack_b%0d_%02h", i, tx_q[i]), 32'(acked), (i == 0) ? 32'(addressed) : 32'd1);
            if (i == 0) check("busy_addr", 32'(busy), 32'(addressed));
            if (i > 0 && (i % 2) == 0) model_commit(tx_q[i - 1], tx_q[i]);
        end
        if (partial > 0) send_bits(pbyte, partial);
        if (addressed && (((nd % 2) == 1) || partial > 0)) exp_err++;
        i2c_stop();
        wait_clk(6);
        check("busy_stop", 32'(busy), 32'd0);
        check("sda_rel", 32'(sda_bus === 1'b1), 32'd1);
        check("err_cnt", 32'(n_err_seen - err0), 32'(exp_err));
        check("n_strobe", 32'(strobe_q.size()), 32'(exp_q.size()));
        nmin = (strobe_q.size() < exp_q.size()) ? strobe_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++)
            check($sformatf("strobe%0d", i), 32'(strobe_q[i]), 32'(exp_q[i]));
        check("wr_last", 32'({wr_addr, wr_data}), 32'(last_word));
        check_regs("regs");
    endtask

    initial begin
        logic [6:0] a;
        logic [8:0] d;
        logic       acked;
        int         sel, partial;
        def_regs = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                     9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
        model_defaults();
        last_word = '0;
        scl = 1'b1; m_low = 1'b0; rd_addr = '0; reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(6);

        check("rst_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr", 32'({wr_addr, wr_data}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_sda", 32'(sda_bus === 1'b1), 32'd1);
        check_regs("rst");
        rd_addr = 4'd12;
        #1;
        check("rd_oob", 32'(rd_data), 32'd0);

        tx_q = '{8'h34, 8'h08, 8'h15};                run_xfer(0, 8'h00);
        tx_q = '{8'h34, 8'h12, 8'h01, 8'h0E, 8'h42};  run_xfer(0, 8'h00);
        tx_q = '{8'h34, 8'h08, 8'h15};                run_xfer(0, 8'h00);
        tx_q = '{8'h34, 8'h1E, 8'h00};                run_xfer(0, 8'h00);
        tx_q = '{8'h36};                              run_xfer(0, 8'h00);
        tx_q = '{8'h35};                              run_xfer(0, 8'h00);
        tx_q = '{8'h34, 8'h08};                       run_xfer(4, 8'hA5);

        for (int t = 0; t < 30; t++) begin
            tx_q.delete();
            sel = $urandom_range(0, 9);
            if (sel < 7) tx_q.push_back(8'h34);
            else if (sel == 7) tx_q.push_back(8'h35);
            else tx_q.push_back(8'($urandom_range(0, 255)));
            if (tx_q[0] == 8'h34) begin
                for (int w = $urandom_range(0, 3); w > 0; w--) begin
                    sel = $urandom_range(0, 15);
                    if (sel < 12) a = 7'($urandom_range(0, 9));
                    else if (sel == 12) a = 7'h0F;
                    else a = 7'($urandom_range(10, 127));
                    d = 9'($urandom_range(0, 511));
                    tx_q.push_back({a, d[8]});
                    tx_q.push_back(d[7:0]);
                end
                if ($urandom_range(0, 4) == 0) tx_q.push_back(8'($urandom_range(0, 255)));
            end
            partial = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
            run_xfer(partial, 8'($urandom_range(0, 255)));
        end

        // Reset in the middle of a data byte: transfer aborted, bus ignored until START
        tx_q = '{8'h34, 8'h08, 8'h15};  run_xfer(0, 8'h00);
        i2c_start();
        send_bits(8'h34, 8);
        ack_bit(acked);
        check("mid_ack", 32'(acked), 32'd1);
        send_bits(8'h08, 4);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        model_defaults();
        last_word = '0;
        strobe_q.delete();
        sel = n_err_seen;
        wait_clk(2);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_wr", 32'({wr_addr, wr_data}), 32'd0);
        send_bits(8'h15, 8);
        ack_bit(acked);
        check("mid_noack", 32'(acked), 32'd0);
        i2c_stop();
        wait_clk(6);
        check("mid_err", 32'(n_err_seen - sel), 32'd0);
        check("mid_strobe", 32'(strobe_q.size()), 32'd0);
        check_regs("mid");
        tx_q = '{8'h34, 8'h12, 8'h01};  run_xfer(0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
